// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding, default 100 MHz timing and GRB reorder helper
package ws2812_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam int T0H_DEF    = 40;
    localparam int T1H_DEF    = 80;
    localparam int TBIT_DEF   = 125;
    localparam int TRESET_DEF = 5000;

    function automatic logic [23:0] grb_reorder(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: bit-period counter and pulse-width high/low decision for one serial bit
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T0H  = T0H_DEF,
    parameter int T1H  = T1H_DEF,
    parameter int TBIT = TBIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic start,
    input  logic bit_val,
    output logic level,
    output logic period_end
);

    localparam int CW = $clog2(TBIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    assign period_end = cnt_q == CW'(TBIT - 1);
    assign level      = level_q;

    // counter and line level for the coming cycle, so the pin itself is a flop
    always_comb begin
        cnt_d   = (!active || start || period_end) ? '0 : cnt_q + 1'b1;
        level_d = active && (cnt_d < (bit_val ? CW'(T1H) : CW'(T0H)));
    end

    // register counter and line; reset forces the line low at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// ws2812_tx: WS2812 serial transmitter with one-word holding register, GRB shifter and latch period
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int T0H    = T0H_DEF,
    parameter int T1H    = T1H_DEF,
    parameter int TBIT   = TBIT_DEF,
    parameter int TRESET = TRESET_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rgb,
    output logic        dout,
    output logic        busy,
    output logic        frame_done
);

    localparam int LW = $clog2(TRESET + 1);

    state_t        state_q, state_d;
    logic [23:0]   hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic [23:0]   sh_q, sh_d;
    logic [4:0]    idx_q, idx_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          in_ready_q, busy_q, frame_done_q, frame_done_d;
    logic          period_end, load;
    logic          unused_rgb_hi;

    assign unused_rgb_hi = ^in_rgb[31:24];
    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

    ws2812_bit_timer #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (state_d == SHIFT),
        .start     (load),
        .bit_val   (sh_d[23]),
        .level     (dout),
        .period_end(period_end)
    );

    // next state: FSM, shifter, latch counter and holding register; a pending word
    // leaves LATCH straight into SHIFT so it starts the cycle after frame_done
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sh_d         = sh_q;
        idx_d        = idx_q;
        lcnt_d       = lcnt_q;
        load         = 1'b0;
        case (state_q)
            IDLE: if (hold_valid_q) begin
                state_d = SHIFT;
                load    = 1'b1;
            end
            SHIFT: if (period_end) begin
                if (idx_q == 5'd23) begin
                    load    = hold_valid_q;
                    state_d = hold_valid_q ? SHIFT : LATCH;
                    lcnt_d  = '0;
                end else begin
                    sh_d  = {sh_q[22:0], 1'b0};
                    idx_d = idx_q + 1'b1;
                end
            end
            LATCH: if (lcnt_q == LW'(TRESET - 1)) begin
                state_d = hold_valid_q ? SHIFT : IDLE;
                load    = hold_valid_q;
            end else begin
                lcnt_d = lcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            sh_d         = hold_q;
            idx_d        = '0;
            hold_valid_d = 1'b0;
        end
        if (in_valid && in_ready_q) begin
            hold_d       = grb_reorder(in_rgb[23:0]);
            hold_valid_d = 1'b1;
        end
        frame_done_d = (state_d == LATCH) && (lcnt_d == LW'(TRESET - 1));
    end

    // state and registered outputs; async reset discards pending and in-flight pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sh_q         <= '0;
            idx_q        <= '0;
            lcnt_q       <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sh_q         <= sh_d;
            idx_q        <= idx_d;
            lcnt_q       <= lcnt_d;
            in_ready_q   <= !hold_valid_d;
            busy_q       <= (state_d != IDLE) || hold_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: randomized self-checking bench comparing the serial line against a frame-level waveform model
module tb_ws2812_tx;

    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TRESET = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_rgb = '0;
    logic        in_ready, dout, busy, frame_done;

    int n_chk = 0;
    int n_pass = 0;

    logic        obs_d[$];
    logic        obs_f[$];
    logic        exp_d[$];
    logic        exp_f[$];
    int          pix_off[$];
    logic [23:0] pix_grb[$];
    logic [31:0] wq[$];
    logic [31:0] dat[147];

    ws2812_tx #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rgb    (in_rgb),
        .dout      (dout),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        obs_d.push_back(dout);
        obs_f.push_back(frame_done);
    end

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    task automatic clear();
        obs_d.delete(); obs_f.delete(); exp_d.delete(); exp_f.delete();
        pix_off.delete(); pix_grb.delete(); wq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one frame: each word as 24 GRB pulse-coded bits, then the latch with frame_done on its last cycle
    function automatic void add_frame();
        logic [23:0] g;
        foreach (wq[p]) begin
            g = {wq[p][15:8], wq[p][23:16], wq[p][7:0]};
            pix_off.push_back(exp_d.size());
            pix_grb.push_back(g);
            for (int b = 23; b >= 0; b--)
                for (int c = 0; c < TBIT; c++) begin
                    exp_d.push_back(c < (g[b] ? T1H : T0H));
                    exp_f.push_back(1'b0);
                end
        end
        for (int c = 0; c < TRESET; c++) begin
            exp_d.push_back(1'b0);
            exp_f.push_back(c == TRESET - 1);
        end
    endfunction

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_rgb   = w;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rgb   = $urandom;
    endtask

    task automatic check_stream(input string tag);
        int st, mism, fo, fe, tail, h, k;
        logic [23:0] w;
        st = -1; mism = 0; fo = 0; fe = 0; tail = 0;
        foreach (obs_d[i]) if (st < 0 && obs_d[i]) st = i;
        chk({tag, "_rise"}, int'(st >= 0), 1);
        if (st < 0) st = 0;
        foreach (exp_d[i])
            if (st + i >= obs_d.size() || obs_d[st+i] !== exp_d[i] || obs_f[st+i] !== exp_f[i]) mism++;
        chk({tag, "_wave"}, mism, 0);
        foreach (pix_off[p]) begin
            w = '0;
            for (int b = 0; b < 24; b++) begin
                h = 0;
                for (int c = 0; c < TBIT; c++) begin
                    k = st + pix_off[p] + b * TBIT + c;
                    if (k < obs_d.size() && obs_d[k]) h++;
                end
                w = {w[22:0], h == T1H};
            end
            chk($sformatf("%s_pix%0d", tag, p), w, pix_grb[p]);
        end
        foreach (obs_f[i]) fo += int'(obs_f[i]);
        foreach (exp_f[i]) fe += int'(exp_f[i]);
        chk({tag, "_fdcount"}, fo, fe);
        for (int i = st + exp_d.size(); i < obs_d.size(); i++) tail += int'(obs_d[i]);
        chk({tag, "_tail"}, tail, 0);
    endtask

    initial begin
        int n, ones, fds;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_fd", frame_done, 0);
        rst_n = 1'b1;
        idle(3);

        // single red pixel
        clear();
        send(32'h00FF0000);
        chk("acc_busy", busy, 1);
        chk("acc_ready", in_ready, 0);
        wq.push_back(32'h00FF0000);
        add_frame();
        idle(exp_d.size() + 20);
        check_stream("red");

        // back-to-back pair
        clear();
        send(32'h00123456);
        send(32'h00ABCDEF);
        wq.push_back(32'h00123456);
        wq.push_back(32'h00ABCDEF);
        add_frame();
        idle(exp_d.size() + 20);
        check_stream("b2b");

        // random back-to-back frames
        for (int r = 0; r < 3; r++) begin
            clear();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                a = $urandom;
                wq.push_back(a);
                send(a);
            end
            add_frame();
            idle(exp_d.size() + 20);
            check_stream($sformatf("rnd%0d", r));
        end

        // word offered during the latch waits for it to finish
        clear();
        a = $urandom;
        b = $urandom;
        send(a);
        idle(148);
        send(b);
        @(negedge clk);
        chk("latch_ready", in_ready, 0);
        chk("latch_busy", busy, 1);
        wq.push_back(a);
        add_frame();
        wq.delete();
        wq.push_back(b);
        add_frame();
        idle(exp_d.size() + 20);
        check_stream("latch");

        // backpressure: only words present on accept edges are sent
        clear();
        in_valid = 1'b1;
        for (int k = 0; k <= 146; k++) begin
            in_rgb = $urandom;
            dat[k] = in_rgb;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wq.push_back(dat[0]);
        wq.push_back(dat[2]);
        wq.push_back(dat[146]);
        add_frame();
        idle(exp_d.size() + 20);
        check_stream("bp");

        // async reset at bit 11 with a second word pending
        clear();
        send(32'h00FFFFFF);
        send(32'h00123456);
        repeat (65) @(posedge clk);
        #2;
        chk("pre_rst_dout", dout, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        clear();
        idle(400);
        ones = 0;
        fds = 0;
        foreach (obs_d[i]) ones += int'(obs_d[i]);
        foreach (obs_f[i]) fds += int'(obs_f[i]);
        chk("post_rst_quiet", ones, 0);
        chk("post_rst_fd", fds, 0);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);

        // all-zero pixel and ignored top byte
        clear();
        send(32'h00000000);
        send(32'hFF000000);
        wq.push_back(32'h00000000);
        wq.push_back(32'hFF000000);
        add_frame();
        idle(exp_d.size() + 20);
        check_stream("zero");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
